// File: rtl/hyperram_pkg.sv
// Shared types and defaults for the HyperRAM request sequencer slice.
// Commands are queued as hr_cmd_t; the sequencer FSM states are exported for debug.
package hyperram_pkg;

  localparam logic [7:0] LAT_1X_DEF = 8'h10;
  localparam logic [7:0] LAT_2X_DEF = 8'd22;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [7:0]  len;
  } hr_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RD_DATA   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/hyperram_cmd_fifo.sv
// Synchronous command FIFO of hr_cmd_t with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module hyperram_cmd_fifo
  import hyperram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  hr_cmd_t wdata,
  input  logic    pop,
  output hr_cmd_t rdata,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  hr_cmd_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hyperram_req_sequencer.sv
// Front-end of the HyperRAM controller: queues commands, issues one request pulse at a time
// and turns controller read strobes into a response stream.
module hyperram_req_sequencer
  import hyperram_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         MAX_BURST   = 8,
  parameter logic [7:0] LAT_1X      = LAT_1X_DEF,
  parameter logic [7:0] LAT_2X      = LAT_2X_DEF,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  // Command stream: a command transfers on a cycle where cmd_valid and cmd_ready are both high;
  // the response stream has no ready and every rsp_valid beat must be consumed.
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        err_len,
  output logic        err_stray,
  output logic        err_timeout,
  output logic        hr_rd_req,
  output logic        hr_wr_req,
  output logic        hr_mem_or_reg,
  output logic [3:0]  hr_wr_byte_en,
  output logic [7:0]  hr_rd_num_dwords,
  output logic [31:0] hr_addr,
  output logic [31:0] hr_wr_d,
  input  logic [31:0] hr_rd_d,
  input  logic        hr_rd_rdy,
  input  logic        hr_busy,
  output logic [7:0]  hr_latency_1x,
  output logic [7:0]  hr_latency_2x,
  output logic [2:0]  dbg_state
);

  seq_state_e state, state_nxt;
  hr_cmd_t    push_cmd, head_cmd;
  logic       fifo_full, fifo_empty;
  logic       push, pop, len_bad;
  logic       cur_we;
  logic [7:0] beat_cnt;
  logic [7:0] ack_timer;
  logic       beat_accept, beat_stray, timeout_hit;

  // Bad-length reads complete the handshake but are never queued.
  assign len_bad   = !cmd_we && ((cmd_len == 8'd0) || (cmd_len > 8'(MAX_BURST)));
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready && !len_bad;
  assign push_cmd  = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, be: cmd_be, len: cmd_len};

  assign hr_mem_or_reg = 1'b0;
  assign hr_latency_1x = LAT_1X;
  assign hr_latency_2x = LAT_2X;
  assign dbg_state     = state;

  hyperram_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    hr_rd_req   = 1'b0;
    hr_wr_req   = 1'b0;
    beat_accept = 1'b0;
    beat_stray  = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !hr_busy) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        hr_wr_req = cur_we;
        hr_rd_req = !cur_we;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (hr_busy) begin
          state_nxt = cur_we ? ST_WAIT_DONE : ST_RD_DATA;
        end else if (ack_timer == 8'(ACK_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!hr_busy) state_nxt = ST_IDLE;
      end
      ST_RD_DATA: begin
        if ((beat_cnt == hr_rd_num_dwords) && !hr_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A read may start streaming before busy is seen; beats beyond the burst length are stray.
    if (hr_rd_rdy) begin
      if (((state == ST_RD_DATA) || ((state == ST_WAIT_ACK) && !cur_we)) &&
          (beat_cnt != hr_rd_num_dwords))
        beat_accept = 1'b1;
      else
        beat_stray = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_we           <= 1'b0;
      hr_addr          <= '0;
      hr_wr_d          <= '0;
      hr_wr_byte_en    <= '0;
      hr_rd_num_dwords <= '0;
      beat_cnt         <= '0;
      ack_timer        <= '0;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_last         <= 1'b0;
      err_len          <= 1'b0;
      err_stray        <= 1'b0;
      err_timeout      <= 1'b0;
    end else begin
      err_len     <= cmd_valid && cmd_ready && len_bad;
      err_stray   <= beat_stray;
      err_timeout <= timeout_hit;
      rsp_valid   <= beat_accept;
      rsp_last    <= beat_accept && ((beat_cnt + 8'd1) == hr_rd_num_dwords);
      if (beat_accept) begin
        rsp_data <= hr_rd_d;
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (pop) begin
        cur_we           <= head_cmd.we;
        hr_addr          <= head_cmd.addr;
        hr_wr_d          <= head_cmd.wdata;
        hr_wr_byte_en    <= head_cmd.be;
        hr_rd_num_dwords <= head_cmd.len;
        beat_cnt         <= '0;
      end
      if (state == ST_ISSUE)         ack_timer <= '0;
      else if (state == ST_WAIT_ACK) ack_timer <= ack_timer + 8'd1;
    end
  end

endmodule

// File: tb/tb_hyperram_req_sequencer.sv
// Directed bench for hyperram_req_sequencer with a small behavioural controller and memory.
module tb_hyperram_req_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid, rsp_last, err_len, err_stray, err_timeout;
  logic [31:0] rsp_data;
  logic        hr_rd_req, hr_wr_req, hr_mem_or_reg;
  logic [3:0]  hr_wr_byte_en;
  logic [7:0]  hr_rd_num_dwords;
  logic [31:0] hr_addr, hr_wr_d, hr_rd_d;
  logic        hr_rd_rdy, hr_busy;
  logic [7:0]  hr_latency_1x, hr_latency_2x;
  logic [2:0]  dbg_state;

  // controller model drive and manual overrides
  logic        model_busy = 1'b0, model_rdy = 1'b0, model_mute = 1'b0;
  logic [31:0] model_d = '0;
  logic        man_busy = 1'b0, man_rdy = 1'b0;
  logic [31:0] man_d = '0;
  logic [31:0] mem [0:1023];

  assign hr_busy   = model_busy | man_busy;
  assign hr_rd_rdy = model_rdy | man_rdy;
  assign hr_rd_d   = man_rdy ? man_d : model_d;

  int checks = 0;
  int errors = 0;

  // monitor state
  logic [31:0] rsp_q[$];
  logic [31:0] exp_q[$];
  logic        last_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  num_q[$];
  int cyc = 0, rd_cnt = 0, wr_cnt = 0, len_cnt = 0, stray_cnt = 0, to_cnt = 0;
  int req_cyc = 0, to_cyc = 0, last_req = 0, min_gap = 1000;
  bit have_req = 1'b0;

  hyperram_req_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_we           (cmd_we),
    .cmd_addr         (cmd_addr),
    .cmd_wdata        (cmd_wdata),
    .cmd_be           (cmd_be),
    .cmd_len          (cmd_len),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_last         (rsp_last),
    .err_len          (err_len),
    .err_stray        (err_stray),
    .err_timeout      (err_timeout),
    .hr_rd_req        (hr_rd_req),
    .hr_wr_req        (hr_wr_req),
    .hr_mem_or_reg    (hr_mem_or_reg),
    .hr_wr_byte_en    (hr_wr_byte_en),
    .hr_rd_num_dwords (hr_rd_num_dwords),
    .hr_addr          (hr_addr),
    .hr_wr_d          (hr_wr_d),
    .hr_rd_d          (hr_rd_d),
    .hr_rd_rdy        (hr_rd_rdy),
    .hr_busy          (hr_busy),
    .hr_latency_1x    (hr_latency_1x),
    .hr_latency_2x    (hr_latency_2x),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // monitor: samples settled outputs just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (hr_rd_req || hr_wr_req) begin
      if (have_req && (cyc - last_req) < min_gap) min_gap = cyc - last_req;
      have_req = 1'b1;
      last_req = cyc;
      addr_q.push_back(hr_addr);
    end
    if (hr_rd_req) begin
      rd_cnt++;
      req_cyc = cyc;
      num_q.push_back(hr_rd_num_dwords);
    end
    if (hr_wr_req) begin
      wr_cnt++;
      wd_q.push_back(hr_wr_d);
    end
    if (rsp_valid) begin
      rsp_q.push_back(rsp_data);
      last_q.push_back(rsp_last);
    end
    if (err_len) len_cnt++;
    if (err_stray) stray_cnt++;
    if (err_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  // controller model: busy one cycle after the request, read beats back to back
  int          m_n;
  logic [9:0]  m_a;
  always begin
    @(negedge clk);
    if (!reset && !model_mute && (hr_rd_req || hr_wr_req)) begin
      m_a = hr_addr[9:0];
      if (hr_wr_req) begin
        for (int b = 0; b < 4; b++)
          if (hr_wr_byte_en[b]) mem[m_a][8*b +: 8] = hr_wr_d[8*b +: 8];
        @(negedge clk);
        model_busy = 1'b1;
        repeat (2) @(negedge clk);
      end else begin
        m_n = int'(hr_rd_num_dwords);
        @(negedge clk);
        model_busy = 1'b1;
        for (int i = 0; i < m_n; i++) begin
          @(negedge clk);
          if (reset) break;
          model_rdy = 1'b1;
          model_d   = mem[10'(m_a + 10'(i))];
        end
        if (!reset) @(negedge clk);
      end
      model_rdy  = 1'b0;
      model_busy = 1'b0;
    end
  end

  // driver tasks
  task automatic clear_mon();
    rsp_q.delete(); last_q.delete(); addr_q.delete(); wd_q.delete(); num_q.delete();
    exp_q.delete();
    rd_cnt = 0; wr_cnt = 0; len_cnt = 0; stray_cnt = 0; to_cnt = 0;
    have_req = 1'b0; min_gap = 1000;
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [7:0] len);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_be = be; cmd_len = len;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_wait cmd_ready got 0 want 1 (addr %h)", addr);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int w = 0;
    while (rsp_q.size() < n && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (rsp_q.size() < n) begin
      checks++; errors++;
      $display("FAIL %s_wait rsp beats got %0d want %0d", tag, rsp_q.size(), n);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++;
    if ({rsp_valid, rsp_last, err_len, err_stray, err_timeout, hr_rd_req, hr_wr_req} !== 7'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b want 0000000",
               {rsp_valid, rsp_last, err_len, err_stray, err_timeout, hr_rd_req, hr_wr_req});
    end
    checks++;
    if ({hr_addr, hr_wr_d, hr_wr_byte_en, hr_rd_num_dwords} !== 76'h0) begin
      errors++;
      $display("FAIL reset_hr_data got %h %h %h %h want 0", hr_addr, hr_wr_d, hr_wr_byte_en, hr_rd_num_dwords);
    end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    checks++;
    if (hr_latency_1x !== 8'h10) begin errors++; $display("FAIL lat_1x got %h want 10", hr_latency_1x); end
    checks++;
    if (hr_latency_2x !== 8'd22) begin errors++; $display("FAIL lat_2x got %0d want 22", hr_latency_2x); end
    checks++;
    if (hr_mem_or_reg !== 1'b0) begin errors++; $display("FAIL mem_or_reg got %b want 0", hr_mem_or_reg); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read();
    clear_mon();
    push_cmd(1'b1, 32'h0, 32'h33, 4'hF, 8'd0);
    push_cmd(1'b0, 32'h0, 32'h0, 4'h0, 8'd1);
    wait_rsp(1, "wr_rd");
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != 1) begin errors++; $display("FAIL wr_rd_wr_pulses got %0d want 1", wr_cnt); end
    checks++;
    if (rd_cnt != 1) begin errors++; $display("FAIL wr_rd_rd_pulses got %0d want 1", rd_cnt); end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 32'h33) begin
      errors++; $display("FAIL wr_rd_data got %h (n=%0d) want 00000033", rsp_q[0], rsp_q.size());
    end
    checks++;
    if (last_q[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_last got %b want 1", last_q[0]); end
    checks++;
    if (min_gap < 3) begin errors++; $display("FAIL req_gap got %0d want >=3", min_gap); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL wr_rd_idle got %0d want 0", dbg_state); end
  endtask

  task automatic test_burst(input logic [7:0] len);
    logic [7:0] lastv;
    clear_mon();
    for (int i = 0; i < int'(len); i++) exp_q.push_back(32'hA0 + 32'(i));
    push_cmd(1'b0, 32'h100, 32'h0, 4'h0, len);
    wait_rsp(int'(len), "burst");
    repeat (10) @(negedge clk);
    checks++;
    if (num_q[0] !== len) begin errors++; $display("FAIL burst_num_dwords got %0d want %0d", num_q[0], len); end
    checks++;
    if (rsp_q.size() != int'(len)) begin
      errors++; $display("FAIL burst_beats got %0d want %0d", rsp_q.size(), len);
    end
    lastv = '0;
    for (int i = 0; i < int'(len); i++) begin
      lastv[i] = last_q[i];
      checks++;
      if (rsp_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL burst_data[%0d] got %h want %h", i, rsp_q[i], exp_q[i]);
      end
    end
    checks++;
    if (lastv !== (8'h01 << (len - 8'd1))) begin
      errors++; $display("FAIL burst_last got %b want %b", lastv, 8'h01 << (len - 8'd1));
    end
  endtask

  task automatic test_full();
    int w = 0;
    clear_mon();
    man_busy = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h10 + 32'(i), 32'h1000 + 32'(i), 4'hF, 8'd0);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'h1004; cmd_be = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held got %b want 0", cmd_ready); end
    checks++;
    if (wr_cnt != 0) begin errors++; $display("FAIL full_no_issue got %0d want 0", wr_cnt); end
    cmd_valid = 1'b0;
    man_busy = 1'b0;
    while (wr_cnt < 4 && w < 300) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != 4) begin errors++; $display("FAIL full_issued got %0d want 4", wr_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_q[i] !== 32'h10 + 32'(i) || wd_q[i] !== 32'h1000 + 32'(i)) begin
        errors++;
        $display("FAIL full_order[%0d] got %h/%h want %h/%h", i, addr_q[i], wd_q[i],
                 32'h10 + 32'(i), 32'h1000 + 32'(i));
      end
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_drained got %b want 1", cmd_ready); end
  endtask

  task automatic test_bad_len();
    clear_mon();
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0, 8'd0);
    push_cmd(1'b0, 32'h40, 32'h0, 4'h0, 8'd9);
    repeat (20) @(negedge clk);
    checks++;
    if (len_cnt != 2) begin errors++; $display("FAIL bad_len_pulses got %0d want 2", len_cnt); end
    checks++;
    if (rd_cnt != 0) begin errors++; $display("FAIL bad_len_no_req got %0d want 0", rd_cnt); end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL bad_len_idle got %0d want 0", dbg_state); end
  endtask

  task automatic test_stray();
    clear_mon();
    @(negedge clk);
    man_rdy = 1'b1; man_d = 32'hDEAD;
    @(negedge clk);
    man_rdy = 1'b0; man_d = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (stray_cnt != 1) begin errors++; $display("FAIL stray_pulses got %0d want 1", stray_cnt); end
    checks++;
    if (rsp_q.size() != 0) begin errors++; $display("FAIL stray_rsp got %0d want 0", rsp_q.size()); end
  endtask

  task automatic test_timeout();
    int w = 0;
    clear_mon();
    model_mute = 1'b1;
    push_cmd(1'b0, 32'h200, 32'h0, 4'h0, 8'd2);
    while (to_cnt == 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (to_cnt != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", to_cnt); end
    checks++;
    if (to_cyc - req_cyc != 16) begin
      errors++; $display("FAIL timeout_delay got %0d want 16", to_cyc - req_cyc);
    end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL timeout_idle got %0d want 0", dbg_state); end
    model_mute = 1'b0;
    push_cmd(1'b1, 32'h300, 32'hCAFE, 4'hF, 8'd0);
    w = 0;
    while (wr_cnt == 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (wr_cnt != 1 || mem[300] === 32'hx) begin end
    if (wr_cnt != 1 || mem[10'h300] !== 32'hCAFE) begin
      errors++; $display("FAIL timeout_recover got %0d/%h want 1/0000cafe", wr_cnt, mem[10'h300]);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    clear_mon();
    push_cmd(1'b0, 32'h80, 32'h0, 4'h0, 8'd4);
    push_cmd(1'b1, 32'h90, 32'h55, 4'hF, 8'd0);
    while (!rsp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, hr_rd_req, hr_wr_req, dbg_state} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_ctrl got %b want 000000", {rsp_valid, hr_rd_req, hr_wr_req, dbg_state});
    end
    checks++;
    if ({hr_addr, hr_rd_num_dwords} !== 40'h0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_data got %h %h ready %b want 0 0 1", hr_addr, hr_rd_num_dwords, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== 32'hB0) begin
      errors++; $display("FAIL rst_mid_rsp got %0d beats first %h want 1 beat b0", rsp_q.size(), rsp_q[0]);
    end
    checks++;
    if (rd_cnt != 1 || wr_cnt != 0) begin
      errors++; $display("FAIL rst_mid_reqs got rd %0d wr %0d want rd 1 wr 0", rd_cnt, wr_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[10'h100 + 10'(i)] = 32'hA0 + 32'(i);
    for (int i = 0; i < 4; i++) mem[10'h080 + 10'(i)] = 32'hB0 + 32'(i);
    test_reset();
    test_write_read();
    test_burst(8'd4);
    test_burst(8'd8);
    test_full();
    test_bad_len();
    test_stray();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
